// File: rtl/wb_timer_pkg.sv
// Shared definitions for the wb_timer machine timer: register word addresses,
// CTRL bit positions, reset constants and the byte-lane merge helper.
package wb_timer_pkg;

    localparam logic [2:0] ADDR_MTIME_LO    = 3'd0;
    localparam logic [2:0] ADDR_MTIME_HI    = 3'd1;
    localparam logic [2:0] ADDR_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] ADDR_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] ADDR_CTRL        = 3'd4;
    localparam logic [2:0] ADDR_PRESCALE    = 3'd5;

    localparam int CTRL_EN_BIT = 0;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Prescaler for wb_timer: counts 0..prescale_i while enabled and emits a
// one-cycle tick on the clock where the count wraps back to zero.
module wb_timer_prescaler
    import wb_timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] prescale_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tick_o = en_i & (cnt_q == prescale_i);

    // Next count: clear wins, wrap on tick, advance while enabled, else hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_timer.sv
// wb_timer: Wishbone B4 classic slave implementing a RISC-V style machine
// timer (64-bit mtime, 64-bit mtimecmp, prescaler, level interrupt).
// Optional build macro WB_TIMER_HI_LATCH_EN: a MTIME_LO read snapshots
// mtime[63:32] so the following MTIME_HI read is tear-free.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 16,
    parameter int PRESCALE_RESET = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [2:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq_o
);

    logic        access_s;
    logic        wr_s;
    logic        rd_s;
    logic        prescale_wr_s;
    logic        tick_s;
    logic [31:0] rdata_s;
    logic [31:0] mtime_hi_rd_s;

    logic        ack_q, ack_d;
    logic        irq_q, irq_d;
    logic [31:0] dat_q, dat_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        en_q, en_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
`ifdef WB_TIMER_HI_LATCH_EN
    logic [31:0] hi_shadow_q, hi_shadow_d;
`endif

    // A new access is only accepted while no ack is outstanding.
    assign access_s      = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_s          = access_s & wb_we_i;
    assign rd_s          = access_s & ~wb_we_i;
    assign prescale_wr_s = wr_s & (wb_adr_i == ADDR_PRESCALE);

`ifdef WB_TIMER_HI_LATCH_EN
    assign mtime_hi_rd_s = hi_shadow_q;
`else
    assign mtime_hi_rd_s = mtime_q[63:32];
`endif

    wb_timer_prescaler #(
        .WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk_i      (wb_clk_i),
        .rst_ni     (wb_rst_i),
        .en_i       (en_q),
        .clr_i      (prescale_wr_s),
        .prescale_i (prescale_q),
        .tick_o     (tick_s)
    );

    // Read data mux over the register map; unmapped words read zero.
    always_comb begin
        rdata_s = 32'd0;
        case (wb_adr_i)
            ADDR_MTIME_LO:    rdata_s = mtime_q[31:0];
            ADDR_MTIME_HI:    rdata_s = mtime_hi_rd_s;
            ADDR_MTIMECMP_LO: rdata_s = mtimecmp_q[31:0];
            ADDR_MTIMECMP_HI: rdata_s = mtimecmp_q[63:32];
            ADDR_CTRL:        rdata_s = 32'(en_q);
            ADDR_PRESCALE:    rdata_s = 32'(prescale_q);
            default:          rdata_s = 32'd0;
        endcase
    end

    // Next-state: bus writes override the tick-driven mtime increment.
    always_comb begin
        ack_d      = access_s;
        dat_d      = rd_s ? rdata_s : dat_q;
        irq_d      = en_q & (mtime_q >= mtimecmp_q);
        mtime_d    = tick_s ? (mtime_q + 64'd1) : mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        prescale_d = prescale_q;
        if (wr_s) begin
            case (wb_adr_i)
                ADDR_MTIME_LO:
                    mtime_d = {mtime_q[63:32], merge_lanes(mtime_q[31:0], wb_dat_i, wb_sel_i)};
                ADDR_MTIME_HI:
                    mtime_d = {merge_lanes(mtime_q[63:32], wb_dat_i, wb_sel_i), mtime_q[31:0]};
                ADDR_MTIMECMP_LO:
                    mtimecmp_d = {mtimecmp_q[63:32], merge_lanes(mtimecmp_q[31:0], wb_dat_i, wb_sel_i)};
                ADDR_MTIMECMP_HI:
                    mtimecmp_d = {merge_lanes(mtimecmp_q[63:32], wb_dat_i, wb_sel_i), mtimecmp_q[31:0]};
                ADDR_CTRL:
                    en_d = wb_sel_i[0] ? wb_dat_i[CTRL_EN_BIT] : en_q;
                ADDR_PRESCALE:
                    prescale_d = PRESCALE_WIDTH'(merge_lanes(32'(prescale_q), wb_dat_i, wb_sel_i));
                default: ;
            endcase
        end else begin
            mtimecmp_d = mtimecmp_q;
        end
    end

`ifdef WB_TIMER_HI_LATCH_EN
    // Snapshot the upper half whenever the lower half is read.
    always_comb begin
        if (rd_s && (wb_adr_i == ADDR_MTIME_LO)) begin
            hi_shadow_d = mtime_q[63:32];
        end else begin
            hi_shadow_d = hi_shadow_q;
        end
    end
`endif

    // State registers with synchronous active-low reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            ack_q       <= 1'b0;
            dat_q       <= 32'd0;
            irq_q       <= 1'b0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= MTIMECMP_RESET;
            en_q        <= 1'b0;
            prescale_q  <= PRESCALE_WIDTH'(PRESCALE_RESET);
`ifdef WB_TIMER_HI_LATCH_EN
            hi_shadow_q <= 32'd0;
`endif
        end else begin
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            irq_q       <= irq_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            en_q        <= en_d;
            prescale_q  <= prescale_d;
`ifdef WB_TIMER_HI_LATCH_EN
            hi_shadow_q <= hi_shadow_d;
`endif
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: a behavioural model predicts each ack,
// read data and the interrupt level; a monitor compares at every falling edge.
module tb_wb_timer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic [2:0]  wb_adr_i = 3'd0;
    logic [31:0] wb_dat_i = 32'd0;
    logic [3:0]  wb_sel_i = 4'd0;
    logic        wb_we_i  = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        irq_o;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_timer dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .irq_o    (irq_o)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        chk;
        logic [31:0] dat;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state (spec-level quantities).
    logic [63:0]     m_mtime  = 64'd0;
    logic [63:0]     m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    logic            m_en     = 1'b0;
    int unsigned     m_pre    = 0;
    longint unsigned m_enclk  = 0;   // enabled clocks since last PRESCALE write
    logic            m_ack    = 1'b0;
    logic            m_irq    = 1'b0;
    logic [31:0]     m_shadow = 32'd0;

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return m_mtime[31:0];
`ifdef WB_TIMER_HI_LATCH_EN
            3'd1: return m_shadow;
`else
            3'd1: return m_mtime[63:32];
`endif
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {31'd0, m_en};
            3'd5: return m_pre;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic        acc, tick, pclr;
        logic [63:0] n_mtime, n_cmp;
        logic        n_en;
        int unsigned n_pre;
        exp_t        e;
        if (!wb_rst_i) begin
            m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_en = 1'b0;
            m_pre = 0; m_enclk = 0; m_ack = 1'b0; m_irq = 1'b0; m_shadow = 32'd0;
            exp_q.delete();
        end else begin
            acc  = wb_cyc_i && wb_stb_i && !m_ack;
            // mtime advances on every (PRESCALE+1)-th enabled clock
            tick = m_en && ((m_enclk % (longint'(m_pre) + 1)) == longint'(m_pre));
            n_mtime = tick ? m_mtime + 64'd1 : m_mtime;
            n_cmp = m_cmp; n_en = m_en; n_pre = m_pre; pclr = 1'b0;
            if (acc && !wb_we_i) begin
                e.chk = 1'b1; e.dat = model_read(wb_adr_i);
                exp_q.push_back(e);
`ifdef WB_TIMER_HI_LATCH_EN
                if (wb_adr_i == 3'd0) m_shadow = m_mtime[63:32];
`endif
            end else if (acc) begin
                e.chk = 1'b0; e.dat = 32'd0;
                exp_q.push_back(e);
                case (wb_adr_i)
                    3'd0: n_mtime = {m_mtime[63:32], lanes(m_mtime[31:0], wb_dat_i, wb_sel_i)};
                    3'd1: n_mtime = {lanes(m_mtime[63:32], wb_dat_i, wb_sel_i), m_mtime[31:0]};
                    3'd2: n_cmp = {m_cmp[63:32], lanes(m_cmp[31:0], wb_dat_i, wb_sel_i)};
                    3'd3: n_cmp = {lanes(m_cmp[63:32], wb_dat_i, wb_sel_i), m_cmp[31:0]};
                    3'd4: if (wb_sel_i[0]) n_en = wb_dat_i[0];
                    3'd5: begin
                        n_pre = lanes(m_pre, wb_dat_i, wb_sel_i) & 32'h0000_FFFF;
                        pclr = 1'b1;
                    end
                    default: ;
                endcase
            end
            m_irq   = m_en && (m_mtime >= m_cmp);
            m_enclk = pclr ? 0 : (m_en ? m_enclk + 1 : m_enclk);
            m_ack   = acc;
            m_mtime = n_mtime; m_cmp = n_cmp; m_en = n_en; m_pre = n_pre;
        end
    endtask

    initial forever begin
        @(posedge wb_clk_i);
        model_step();
    end

    // Monitor: ack timing, read data and interrupt level against the model.
    initial forever begin
        exp_t e;
        @(negedge wb_clk_i);
        if (wb_ack_o === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL ack_timing: ack high with no access outstanding, t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (e.chk && (wb_dat_o !== e.dat)) begin
                    fails++;
                    $display("FAIL rdata: got %h expected %h, t=%0t", wb_dat_o, e.dat, $time);
                end
            end
        end else if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL ack_timing: ack %b expected 1, t=%0t", wb_ack_o, $time);
            exp_q.delete();
        end
        tests++;
        if (irq_o !== m_irq) begin
            fails++;
            $display("FAIL irq: got %b expected %b, t=%0t", irq_o, m_irq, $time);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic bus(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdat);
        logic got;
        got = 1'b0; rdat = 32'd0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge wb_clk_i);
            if (wb_ack_o === 1'b1) begin
                rdat = wb_dat_o; got = 1'b1;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL bus_timeout: no ack for adr %0d", adr);
        end
    endtask

    task automatic wr(input logic [2:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        bus(1'b1, adr, dat, 4'hF, d);
    endtask

    task automatic rd(input logic [2:0] adr, output logic [31:0] d);
        bus(1'b0, adr, 32'd0, 4'hF, d);
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
    endtask

    logic [31:0] rv;
    logic [31:0] reset_exp [8];

    initial begin
        reset_exp = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;

        // Reset values over the whole map
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), rv);
            check($sformatf("reset_read_%0d", a), {32'd0, rv}, {32'd0, reset_exp[a]});
        end

        // Byte lanes on MTIMECMP_LO
        bus(1'b1, 3'd2, 32'hAABB_CCDD, 4'b0101, rv);
        rd(3'd2, rv);
        check("byte_lanes", {32'd0, rv}, {32'd0, 32'hFFBB_FFDD});

        // Prescaler: PRESCALE=3, enabled for 41 edges -> 10 ticks
        do_reset();
        wr(3'd5, 32'd3);
        wr(3'd4, 32'd1);
        repeat (40) @(negedge wb_clk_i);
        wr(3'd4, 32'd0);
        rd(3'd0, rv);
        tests++;
        if (rv < 32'd9 || rv > 32'd11) begin
            fails++;
            $display("FAIL prescale_count: got %0d expected 9..11", rv);
        end

        // Interrupt rise and clear
        do_reset();
        wr(3'd3, 32'd0);
        wr(3'd2, 32'd20);
        wr(3'd5, 32'd0);
        wr(3'd4, 32'd1);
        for (int i = 0; i < 80; i++) begin
            @(negedge wb_clk_i);
            if (irq_o === 1'b1) break;
        end
        check("irq_rise", {63'd0, irq_o}, 64'd1);
        wr(3'd2, 32'd100);
        @(negedge wb_clk_i);
        check("irq_clear", {63'd0, irq_o}, 64'd0);

        // 64-bit wrap: FFFFFFFF_FFFFFFFE plus 5 ticks is 3
        do_reset();
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd0, 32'hFFFF_FFFE);
        wr(3'd4, 32'd1);
        repeat (4) @(negedge wb_clk_i);
        wr(3'd4, 32'd0);
        rd(3'd0, rv);
        check("wrap_lo", {32'd0, rv}, 64'd3);
        rd(3'd1, rv);
        check("wrap_hi", {32'd0, rv}, 64'd0);

        // Write on a tick edge holds at 5; one tick occurs before the read samples
        do_reset();
        wr(3'd1, 32'd7);
        wr(3'd4, 32'd1);
        repeat (3) @(negedge wb_clk_i);
        wr(3'd0, 32'd5);
        rd(3'd0, rv);
        check("collide_lo", {32'd0, rv}, 64'd6);
        rd(3'd1, rv);
        check("collide_hi", {32'd0, rv}, 64'd7);

        // Tear-free read ordering across a LO->HI carry
        do_reset();
        wr(3'd0, 32'hFFFF_FFF0);
        wr(3'd4, 32'd1);
        rd(3'd0, rv);
        repeat (32) @(negedge wb_clk_i);
        rd(3'd1, rv);
`ifdef WB_TIMER_HI_LATCH_EN
        check("hi_latch", {32'd0, rv}, 64'd0);
`else
        check("hi_live", {32'd0, rv}, 64'd1);
`endif

        // Reset coinciding with an access discards the write
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 3'd2; wb_dat_i = 32'h0000_1234; wb_sel_i = 4'hF;
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_rst_i = 1'b1;
        rd(3'd2, rv);
        check("reset_drops_write", {32'd0, rv}, 64'h0000_0000_FFFF_FFFF);

        // Randomised traffic checked by the model/monitor
        for (int n = 0; n < 250; n++) begin
            logic [2:0]  a;
            logic [31:0] d;
            logic        we;
            if ($urandom_range(0, 79) == 0) do_reset();
            a  = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            case (a)
                3'd1, 3'd3: d = $urandom_range(0, 1);
                3'd0, 3'd2: d = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 200) : $urandom;
                3'd4:       d = $urandom_range(0, 3);
                3'd5:       d = $urandom_range(0, 4);
                default:    d = $urandom;
            endcase
            bus(we, a, d, 4'($urandom_range(0, 15)), rv);
            repeat ($urandom_range(0, 3)) @(negedge wb_clk_i);
        end

        repeat (4) @(negedge wb_clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
